instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Instruction fetch stage sitting directly upstream of the single-cycle datapath. Issues in-order,
//  word-aligned reads to instruction memory over a req/gnt + rvalid bus, buffers returned words with
//  their PCs in a small prefetch queue, and presents {instr, instr_pc} to the core via valid/ready.
//  Branch/jump redirects flush the queue and squash in-flight responses.
// PARAMETERS
//  DEPTH            2             prefetch queue entries (power of 2, >=2)
//  MAX_OUTSTANDING  2             max granted-but-unreturned requests (<=DEPTH)
//  RESET_PC         32'h0000_0000 first fetch address after reset
// PORTS
//  clk          in   1   clock, all state on rising edge
//  reset        in   1   synchronous, active-high
//  redirect     in   1   pulse: discard everything, restart fetch at redirect_pc
//  redirect_pc  in   32  new fetch address; bits[1:0] forced to 0
//  instr_ready  in   1   core accepts head entry this cycle
//  instr_valid  out  1   head entry valid
//  instr        out  32  head instruction word
//  instr_pc     out  32  address of head instruction
//  imem_req     out  1   read request
//  imem_addr    out  32  request address, word-aligned
//  imem_gnt     in   1   request accepted this cycle
//  imem_rvalid  in   1   read data returned (in order, >=1 cycle after its gnt)
//  imem_rdata   in   32  returned word
// BEHAVIOUR
//  Reset: fetch_pc=RESET_PC, resp_pc=RESET_PC, queue empty, outstanding=0, discard=0;
//   outputs imem_req=0, instr_valid=0, instr/instr_pc=0. Reset mid-transfer drops all state;
//   responses arriving after reset to pre-reset requests are not tracked (bus is reset together).
//  Issue: imem_req=1 iff !reset & !redirect & (occupancy+outstanding)<DEPTH & outstanding<MAX_OUTSTANDING;
//   imem_addr=fetch_pc. Credit rule guarantees the queue never overflows; no push is ever refused.
//   req&gnt -> fetch_pc+=4 (mod 2^32, wraps silently), outstanding+1. imem_addr stable while req&!gnt.
//  Response: rvalid -> outstanding-1. If discard>0: drop word, discard-1. Else push {resp_pc, rdata},
//   resp_pc+=4.
//  Output: instr_valid=queue non-empty; instr/instr_pc=head (registered, no comb path from rdata).
//   instr_valid&instr_ready pops. Push and pop in same cycle legal at any occupancy incl. full.
//   Minimum latency: rvalid in cycle N -> instr_valid in N+1.
//  Redirect (highest priority over push/pop/issue in its cycle): queue flushed (instr_valid=0 next
//   cycle, pop ignored), imem_req=0 that cycle, fetch_pc=resp_pc=redirect_pc&~3,
//   discard <= outstanding - rvalid (response arriving in the redirect cycle is also dropped).
//   Back-to-back redirects: each recomputes discard from current outstanding; last target wins.
//  Counters: outstanding, discard sized clog2(MAX_OUTSTANDING+1); discard<=outstanding always.
// STRUCTURE
//  Shared package (core_pkg): XLEN=32, ILEN=32, RESET_PC default, fetch_entry_t {pc, instr}.
//  One sub-module: fetch_queue -- synchronous FIFO of fetch_entry_t, DEPTH entries, flush input,
//   count output; wrap-around pointers with extra bit for full/empty.
//  Top holds fetch_pc, resp_pc, outstanding/discard counters and issue logic only.
// TESTING
//  Reset release, gnt=1 always, rvalid 1 cycle after gnt -> addrs 0,4,8..; instr_pc 0,4,8 in order.
//  instr_ready=0 forever, DEPTH=2 -> exactly 2 grants, then imem_req=0 held; no entry lost.
//  2 outstanding, redirect to 0x100 -> next 2 rvalids dropped; first instr_pc=0x100.
//  Redirect in same cycle as rvalid with 1 outstanding -> discard=0, next req addr 0x100.
//  redirect_pc=0x203 -> imem_addr=0x200, instr_pc=0x200.
//  fetch_pc=0xFFFF_FFFC -> next imem_addr=0x0; reset asserted mid-stall -> instr_valid=0 next cycle.

Source files
------------

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared core types and constants. Defines the machine word
//                widths, the default reset PC and the prefetch-queue entry
//                type {pc, instr}, plus a word-alignment helper.
//  Revision    : 1.0  initial release
// ============================================================================
package core_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    // Clears the two byte-offset bits so every fetch is word aligned.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage : core_pkg
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Synchronous FIFO of fetch_entry_t with flush. Wrap-around
//                pointers carry one extra bit to tell full from empty.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                i_flush        - drop all entries (wins over push/pop)
//                i_push/i_data  - write one entry
//                i_pop          - retire head entry (ignored when empty)
//                o_head         - current head entry (from storage)
//                o_empty/o_full - status, o_count - occupancy
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_queue
    import core_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  fetch_entry_t           i_data,
    input  logic                   i_pop,
    output fetch_entry_t           o_head,
    output logic                   o_empty,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int c_pw = $clog2(DEPTH);

    fetch_entry_t      r_mem [DEPTH];
    logic [c_pw:0]     r_wr_ptr;
    logic [c_pw:0]     r_rd_ptr;
    logic              w_do_pop;

    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_pw] != r_rd_ptr[c_pw]) &&
                     (r_wr_ptr[c_pw-1:0] == r_rd_ptr[c_pw-1:0]);
    assign o_head  = r_mem[r_rd_ptr[c_pw-1:0]];
    assign w_do_pop = i_pop && !o_empty;

    // Storage needs no reset: it is only visible through a non-empty head.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr[c_pw-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule : fetch_queue
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : In-order instruction fetch with a small prefetch queue.
//                Issues word-aligned reads over req/gnt + rvalid, tags each
//                returned word with its PC and presents it via valid/ready.
//                Redirects flush the queue and squash in-flight responses.
//  Ports       : clk, reset                 - clock, sync active-high reset
//                redirect, redirect_pc      - restart fetch at a new PC
//                instr_valid/ready, instr, instr_pc - core-side handshake
//                imem_req/addr/gnt          - request channel
//                imem_rvalid/rdata          - in-order response channel
//  Revision    : 1.0  initial release
// ============================================================================
module instr_fetch_unit
    import core_pkg::*;
#(
    parameter int              DEPTH           = 2,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            instr_ready,
    output logic            instr_valid,
    output logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata
);

    localparam int c_ow  = $clog2(MAX_OUTSTANDING + 1);
    localparam int c_qcw = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic [c_ow-1:0] r_outstanding;
    logic [c_ow-1:0] r_discard;

    logic             w_empty;
    logic             w_full;
    logic [c_qcw-1:0] w_count;
    fetch_entry_t     w_head;
    fetch_entry_t     w_push_data;
    logic             w_push;
    logic             w_pop;
    logic             w_issue;
    logic [31:0]      w_credit_used;

    // Queue slots already spoken for: buffered entries plus words in flight.
    // Keeping this below DEPTH means a returning word always has room.
    assign w_credit_used = 32'(w_count) + 32'(r_outstanding);

    assign imem_req  = !reset && !redirect &&
                       (w_credit_used < 32'(DEPTH)) &&
                       (32'(r_outstanding) < 32'(MAX_OUTSTANDING));
    assign imem_addr = r_fetch_pc;
    assign w_issue   = imem_req && imem_gnt;

    assign w_push      = imem_rvalid && (r_discard == '0) && !redirect && !reset;
    assign w_push_data = '{pc: r_resp_pc, instr: imem_rdata};
    assign w_pop       = instr_valid && instr_ready && !redirect;

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_fetch_queue (
        .clk     (clk),
        .rst     (reset),
        .i_flush (redirect),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_count)
    );

    // Head comes straight from queue storage; masking with valid keeps the
    // outputs at zero whenever nothing is presented (including after reset).
    assign instr_valid = !w_empty;
    assign instr       = w_empty ? '0 : w_head.instr;
    assign instr_pc    = w_empty ? '0 : w_head.pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else if (redirect) begin
            // No issue happens in a redirect cycle, so every word still in
            // flight afterwards belongs to the old stream and must be dropped.
            r_fetch_pc    <= word_align(redirect_pc);
            r_resp_pc     <= word_align(redirect_pc);
            r_outstanding <= r_outstanding - c_ow'(imem_rvalid);
            r_discard     <= r_outstanding - c_ow'(imem_rvalid);
        end else begin
            if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            r_outstanding <= r_outstanding + c_ow'(w_issue) - c_ow'(imem_rvalid);
            if (imem_rvalid) begin
                if (r_discard != '0) begin
                    r_discard <= r_discard - 1'b1;
                end else begin
                    r_resp_pc <= r_resp_pc + 32'd4;
                end
            end
        end
    end

endmodule : instr_fetch_unit
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Self-checking bench for instr_fetch_unit. A behavioural
//                memory answers granted requests in order; returned words
//                that belong to the current stream are queued as expected
//                entries and compared when the core side pops them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instr_fetch_unit;
    import core_pkg::*;

    localparam int              DEPTH    = 2;
    localparam int              MAXO     = 2;
    localparam logic [XLEN-1:0] RST_PC   = 32'h0000_0000;

    logic            clk;
    logic            reset;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            instr_ready;
    logic            instr_valid;
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [ILEN-1:0] imem_rdata;

    instr_fetch_unit #(
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAXO),
        .RESET_PC        (RST_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_ready (instr_ready),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] addr;
        bit              drop;
        int              cyc;
    } pend_t;

    pend_t           pend[$];
    fetch_entry_t    exp_q[$];
    logic [XLEN-1:0] pop_log[$];
    logic [XLEN-1:0] exp_fetch;
    int              cyc;
    int              n_grants;
    int              n_cmp;
    int              n_fail;

    bit              drv_reset, drv_redirect, drv_ready, drv_gnt, drv_rsp_en;
    logic [XLEN-1:0] drv_rpc;

    logic            s_req, s_valid;
    logic [XLEN-1:0] s_addr, s_pc;
    logic [ILEN-1:0] s_instr;

    function automatic logic [ILEN-1:0] data_of(input logic [XLEN-1:0] a);
        return (a * 32'd3) ^ 32'hC0DE_1234;
    endfunction

    // One clock cycle: drive at the falling edge, sample 1 time unit later,
    // then update the memory model and scoreboard after the rising edge.
    task automatic step();
        bit           rv;
        bit           exp_req;
        pend_t        h;
        fetch_entry_t e;
        rv = !drv_reset && drv_rsp_en && (pend.size() > 0) && (cyc > pend[0].cyc);
        reset       = drv_reset;
        redirect    = drv_redirect;
        redirect_pc = drv_rpc;
        instr_ready = drv_ready;
        imem_gnt    = drv_gnt;
        imem_rvalid = rv;
        imem_rdata  = rv ? data_of(pend[0].addr) : $urandom;
        #1;
        s_req = imem_req; s_addr = imem_addr; s_valid = instr_valid;
        s_pc  = instr_pc; s_instr = instr;
        if (drv_reset) begin
            n_cmp++;
            if (s_req !== 1'b0) begin
                n_fail++; $display("FAIL req_in_reset: got %b expected 0", s_req);
            end
        end else begin
            exp_req = !drv_redirect && (exp_q.size() + pend.size() < DEPTH) && (pend.size() < MAXO);
            n_cmp++;
            if (s_req !== exp_req) begin
                n_fail++; $display("FAIL req cyc%0d: got %b expected %b", cyc, s_req, exp_req);
            end
            if (s_req === 1'b1) begin
                n_cmp++;
                if (s_addr !== exp_fetch) begin
                    n_fail++; $display("FAIL addr cyc%0d: got %h expected %h", cyc, s_addr, exp_fetch);
                end
            end
            n_cmp++;
            if (s_valid !== (exp_q.size() != 0)) begin
                n_fail++; $display("FAIL valid cyc%0d: got %b expected %b", cyc, s_valid, exp_q.size() != 0);
            end
            if (s_valid === 1'b1 && drv_ready && !drv_redirect && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                pop_log.push_back(s_pc);
                n_cmp++;
                if (s_pc !== e.pc || s_instr !== e.instr) begin
                    n_fail++;
                    $display("FAIL pop cyc%0d: got pc=%h instr=%h expected pc=%h instr=%h",
                             cyc, s_pc, s_instr, e.pc, e.instr);
                end
            end
        end
        @(posedge clk);
        if (drv_reset) begin
            pend.delete(); exp_q.delete(); pop_log.delete();
            exp_fetch = RST_PC; n_grants = 0;
        end else begin
            if (rv) begin
                h = pend.pop_front();
                if (!h.drop && !drv_redirect) begin
                    exp_q.push_back('{pc: h.addr, instr: data_of(h.addr)});
                end
            end
            if (s_req === 1'b1 && drv_gnt) begin
                pend.push_back('{addr: s_addr, drop: 1'b0, cyc: cyc});
                exp_fetch = exp_fetch + 32'd4;
                n_grants++;
            end
            if (drv_redirect) begin
                foreach (pend[i]) pend[i].drop = 1'b1;
                exp_q.delete();
                exp_fetch = {drv_rpc[XLEN-1:2], 2'b00};
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wait_pops(input int n, input int budget);
        int b;
        b = budget;
        while (pop_log.size() < n && b > 0) begin
            step(); b--;
        end
        if (pop_log.size() < n) begin
            n_cmp++; n_fail++;
            $display("FAIL timeout_pops: got %0d expected %0d", pop_log.size(), n);
        end
    endtask

    task automatic idle_defaults();
        drv_reset = 0; drv_redirect = 0; drv_rpc = '0;
        drv_ready = 1; drv_gnt = 1; drv_rsp_en = 1;
    endtask

    task automatic do_reset();
        idle_defaults();
        drv_reset = 1;
        run(2);
        drv_reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (instr_valid !== 1'b0 || instr !== '0 || instr_pc !== '0 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got valid=%b instr=%h pc=%h req=%b expected 0/0/0/0",
                     instr_valid, instr, instr_pc, imem_req);
        end
    endtask

    task automatic test_stream();
        do_reset();
        wait_pops(6, 40);
        n_cmp++;
        if (pop_log.size() < 6 || pop_log[0] !== 32'h0 || pop_log[1] !== 32'h4 || pop_log[2] !== 32'h8) begin
            n_fail++; $display("FAIL stream_order: got first pcs not 0,4,8 (n=%0d)", pop_log.size());
        end
    endtask

    task automatic test_stall();
        do_reset();
        drv_ready = 0;
        run(10);
        n_cmp++;
        if (n_grants != 2 || s_req !== 1'b0) begin
            n_fail++; $display("FAIL stall_grants: got %0d req=%b expected 2 req=0", n_grants, s_req);
        end
        drv_ready = 1; drv_gnt = 0;
        wait_pops(2, 10);
        n_cmp++;
        if (pop_log.size() != 2 || pop_log[0] !== 32'h0 || pop_log[1] !== 32'h4) begin
            n_fail++; $display("FAIL stall_drain: got %0d entries expected pcs 0,4", pop_log.size());
        end
    endtask

    task automatic test_redirect_flush();
        do_reset();
        drv_rsp_en = 0;
        run(3);
        drv_redirect = 1; drv_rpc = 32'h100;
        step();
        drv_redirect = 0; drv_rsp_en = 1;
        wait_pops(2, 30);
        n_cmp++;
        if (pop_log.size() < 2 || pop_log[0] !== 32'h100 || pop_log[1] !== 32'h104) begin
            n_fail++; $display("FAIL redirect_flush: got first pc %h expected 100",
                               pop_log.size() > 0 ? pop_log[0] : 32'hx);
        end
    endtask

    task automatic test_redirect_with_rvalid();
        logic [XLEN-1:0] a0;
        do_reset();
        drv_rsp_en = 0;
        step();
        drv_gnt = 0;
        step(); a0 = s_addr;
        step();
        n_cmp++;
        if (s_addr !== a0 || s_addr !== 32'h4) begin
            n_fail++; $display("FAIL addr_stable: got %h expected 00000004", s_addr);
        end
        drv_rsp_en = 1; drv_redirect = 1; drv_rpc = 32'h100;
        step();
        drv_redirect = 0;
        step();
        n_cmp++;
        if (s_req !== 1'b1 || s_addr !== 32'h100) begin
            n_fail++; $display("FAIL redirect_rvalid_addr: got req=%b addr=%h expected 1/100", s_req, s_addr);
        end
        drv_gnt = 1;
        wait_pops(1, 20);
        n_cmp++;
        if (pop_log.size() < 1 || pop_log[0] !== 32'h100) begin
            n_fail++; $display("FAIL redirect_rvalid_pc: got %h expected 100",
                               pop_log.size() > 0 ? pop_log[0] : 32'hx);
        end
    endtask

    task automatic test_align();
        do_reset();
        drv_redirect = 1; drv_rpc = 32'h203;
        step();
        drv_redirect = 0;
        step();
        n_cmp++;
        if (s_addr !== 32'h200) begin
            n_fail++; $display("FAIL align_addr: got %h expected 00000200", s_addr);
        end
        wait_pops(1, 20);
        n_cmp++;
        if (pop_log.size() < 1 || pop_log[0] !== 32'h200) begin
            n_fail++; $display("FAIL align_pc: got %h expected 200", pop_log.size() > 0 ? pop_log[0] : 32'hx);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        drv_redirect = 1; drv_rpc = 32'hFFFF_FFFC;
        step();
        drv_redirect = 0;
        wait_pops(2, 20);
        n_cmp++;
        if (pop_log.size() < 2 || pop_log[0] !== 32'hFFFF_FFFC || pop_log[1] !== 32'h0) begin
            n_fail++; $display("FAIL wrap: got %0d pops expected pcs FFFFFFFC,0", pop_log.size());
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drv_rsp_en = 0;
        run(3);
        drv_redirect = 1; drv_rpc = 32'h300;
        step();
        drv_rsp_en = 1; drv_rpc = 32'h400;
        step();
        drv_redirect = 0;
        wait_pops(2, 30);
        n_cmp++;
        if (pop_log.size() < 2 || pop_log[0] !== 32'h400 || pop_log[1] !== 32'h404) begin
            n_fail++; $display("FAIL back_to_back: got first pc %h expected 400",
                               pop_log.size() > 0 ? pop_log[0] : 32'hx);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drv_ready = 0;
        run(6);
        drv_reset = 1;
        step();
        n_cmp++;
        if (instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_stall: got valid=%b expected 0", instr_valid);
        end
        drv_reset = 0; drv_ready = 1;
        wait_pops(1, 20);
        n_cmp++;
        if (pop_log.size() < 1 || pop_log[0] !== RST_PC) begin
            n_fail++; $display("FAIL restart_after_reset: got %h expected %h",
                               pop_log.size() > 0 ? pop_log[0] : 32'hx, RST_PC);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drv_gnt      = ($urandom_range(0, 3) != 0);
            drv_rsp_en   = ($urandom_range(0, 2) != 0);
            drv_ready    = ($urandom_range(0, 1) != 0);
            drv_redirect = ($urandom_range(0, 15) == 0);
            drv_rpc      = $urandom;
            step();
        end
        idle_defaults();
        run(10);
        n_cmp++;
        if (pop_log.size() < 20) begin
            n_fail++; $display("FAIL random_progress: got %0d pops expected >=20", pop_log.size());
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; cyc = 0; n_grants = 0; exp_fetch = RST_PC;
        idle_defaults();
        reset = 1; redirect = 0; redirect_pc = '0; instr_ready = 0;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_stall();
        test_redirect_flush();
        test_redirect_with_rvalid();
        test_align();
        test_wrap();
        test_back_to_back();
        test_reset_mid_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_instr_fetch_unit
`default_nettype wire
